// File: rtl/sip_out_fifo_core.sv
// Core storage and flag logic of the output FIFO: ten 8-bit lanes per write, 4-bit nibbles
// (lanes 5/6 8-bit) per read, 8 entries deep, single clock with registered status flags.
module sip_out_fifo_core #(
  parameter logic [7:0] ALMOST_EMPTY_VALUE = 8'h41,
  parameter logic [7:0] ALMOST_FULL_VALUE  = 8'h41,
  parameter logic       ARRAY_MODE         = 1'b1,
  parameter logic       OUTPUT_DISABLE     = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GSR,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  input  logic [7:0] D4,
  input  logic [7:0] D5,
  input  logic [7:0] D6,
  input  logic [7:0] D7,
  input  logic [7:0] D8,
  input  logic [7:0] D9,
  input  logic       WREN,
  input  logic       RDEN,
  input  logic       TESTWRITEDISB,
  input  logic       TESTREADDISB,
  input  logic       TESTMODEB,
  input  logic       SCANENB,
  input  logic [3:0] SCANIN,
  output logic [3:0] Q0,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] Q3,
  output logic [3:0] Q4,
  output logic [7:0] Q5,
  output logic [7:0] Q6,
  output logic [3:0] Q7,
  output logic [3:0] Q8,
  output logic [3:0] Q9,
  output logic       EMPTY,
  output logic       ALMOSTEMPTY,
  output logic       FULL,
  output logic       ALMOSTFULL,
  output logic [3:0] SCANOUT
);

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANES   = 10;
  localparam int unsigned LANE_W  = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned ENTRY_W = LANES * LANE_W;

  // Encoded thresholds: 8'h63 selects a margin of 2, anything else a margin of 1.
  localparam logic [CNT_W-1:0] AE_C     = (ALMOST_EMPTY_VALUE == 8'h63) ? CNT_W'(2) : CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_C     = (ALMOST_FULL_VALUE  == 8'h63) ? CNT_W'(2) : CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LIM   = FULL_CNT - AF_C;

  logic                 rst_w;
  logic [ENTRY_W-1:0]   d_entry;
  logic [ENTRY_W-1:0]   rd_entry;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 phase_q, phase_d;
  logic [NIB_W-1:0]     nib_q [LANES];
  logic [NIB_W-1:0]     nib_d [LANES];
  logic [NIB_W-1:0]     hi5_q, hi5_d;
  logic [NIB_W-1:0]     hi6_q, hi6_d;
  logic                 empty_q, empty_d;
  logic                 aempty_q, aempty_d;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 pop;
  logic                 q_en_c;
  logic                 unused_ok;

  assign rst_w    = RESET | GSR;
  assign d_entry  = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};
  assign rd_entry = mem_q[rd_ptr_q];

  // Accepts are qualified by the registered flags present at the edge.
  assign wr_acc = WREN & ~full_q & TESTWRITEDISB;
  assign rd_acc = RDEN & ~empty_q & TESTREADDISB;
  assign pop    = rd_acc & (~ARRAY_MODE | phase_q);

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= d_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    phase_d  = phase_q;
    hi5_d    = hi5_q;
    hi6_d    = hi6_q;
    for (int l = 0; l < LANES; l++) begin
      nib_d[l] = nib_q[l];
    end

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (rd_acc) begin
      // 8x4 mode returns the low nibble on phase 0 and the high nibble on phase 1.
      for (int l = 0; l < LANES; l++) begin
        nib_d[l] = (ARRAY_MODE && phase_q) ? rd_entry[l*LANE_W + NIB_W +: NIB_W]
                                           : rd_entry[l*LANE_W +: NIB_W];
      end
      hi5_d = ARRAY_MODE ? NIB_W'(0) : rd_entry[5*LANE_W + NIB_W +: NIB_W];
      hi6_d = ARRAY_MODE ? NIB_W'(0) : rd_entry[6*LANE_W + NIB_W +: NIB_W];
      if (ARRAY_MODE) begin
        phase_d = ~phase_q;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
    empty_d  = (count_d == CNT_W'(0));
    aempty_d = (count_d <= AE_C);
    full_d   = (count_d == FULL_CNT);
    afull_d  = (count_d >= AF_LIM);
  end

  always_ff @(posedge CLK or posedge rst_w) begin
    if (rst_w) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= 1'b0;
      hi5_q    <= '0;
      hi6_q    <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        nib_q[l] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      hi5_q    <= hi5_d;
      hi6_q    <= hi6_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      for (int l = 0; l < LANES; l++) begin
        nib_q[l] <= nib_d[l];
      end
    end
  end

  // Optional gating of the read data while no read is requested.
  assign q_en_c = ~(OUTPUT_DISABLE & ~RDEN);

  assign Q0 = q_en_c ? nib_q[0] : '0;
  assign Q1 = q_en_c ? nib_q[1] : '0;
  assign Q2 = q_en_c ? nib_q[2] : '0;
  assign Q3 = q_en_c ? nib_q[3] : '0;
  assign Q4 = q_en_c ? nib_q[4] : '0;
  assign Q5 = q_en_c ? {hi5_q, nib_q[5]} : '0;
  assign Q6 = q_en_c ? {hi6_q, nib_q[6]} : '0;
  assign Q7 = q_en_c ? nib_q[7] : '0;
  assign Q8 = q_en_c ? nib_q[8] : '0;
  assign Q9 = q_en_c ? nib_q[9] : '0;

  assign EMPTY       = empty_q;
  assign ALMOSTEMPTY = aempty_q;
  assign FULL        = full_q;
  assign ALMOSTFULL  = afull_q;
  assign SCANOUT     = 4'h0;

  assign unused_ok = &{1'b0, TESTMODEB, SCANENB, SCANIN};

endmodule

// File: tb/tb_sip_out_fifo_core.sv
// Directed bench: instance a is 8x4 with default thresholds; instance b is 4x4 with output
// disable and an almost-empty margin of 2.
module tb_sip_out_fifo_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gsr = 1'b0;
  logic [7:0] d [10];
  logic       a_wr = 1'b0, a_rd = 1'b0, b_wr = 1'b0, b_rd = 1'b0;

  logic [3:0] a_qn [8];
  logic [7:0] a_q5, a_q6;
  logic       a_e, a_ae, a_f, a_af;
  logic [3:0] a_so;
  logic [3:0] b_qn [8];
  logic [7:0] b_q5, b_q6;
  logic       b_e, b_ae, b_f, b_af;
  logic [3:0] b_so;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sip_out_fifo_core #(
    .ALMOST_EMPTY_VALUE(8'h41), .ALMOST_FULL_VALUE(8'h41),
    .ARRAY_MODE(1'b1), .OUTPUT_DISABLE(1'b0)
  ) u_a (
    .CLK(clk), .RESET(rst), .GSR(gsr),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]),
    .D5(d[5]), .D6(d[6]), .D7(d[7]), .D8(d[8]), .D9(d[9]),
    .WREN(a_wr), .RDEN(a_rd), .TESTWRITEDISB(1'b1), .TESTREADDISB(1'b1),
    .TESTMODEB(1'b1), .SCANENB(1'b1), .SCANIN(4'h0),
    .Q0(a_qn[0]), .Q1(a_qn[1]), .Q2(a_qn[2]), .Q3(a_qn[3]), .Q4(a_qn[4]),
    .Q5(a_q5), .Q6(a_q6), .Q7(a_qn[5]), .Q8(a_qn[6]), .Q9(a_qn[7]),
    .EMPTY(a_e), .ALMOSTEMPTY(a_ae), .FULL(a_f), .ALMOSTFULL(a_af), .SCANOUT(a_so)
  );

  sip_out_fifo_core #(
    .ALMOST_EMPTY_VALUE(8'h63), .ALMOST_FULL_VALUE(8'h41),
    .ARRAY_MODE(1'b0), .OUTPUT_DISABLE(1'b1)
  ) u_b (
    .CLK(clk), .RESET(rst), .GSR(gsr),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]),
    .D5(d[5]), .D6(d[6]), .D7(d[7]), .D8(d[8]), .D9(d[9]),
    .WREN(b_wr), .RDEN(b_rd), .TESTWRITEDISB(1'b1), .TESTREADDISB(1'b1),
    .TESTMODEB(1'b1), .SCANENB(1'b1), .SCANIN(4'h0),
    .Q0(b_qn[0]), .Q1(b_qn[1]), .Q2(b_qn[2]), .Q3(b_qn[3]), .Q4(b_qn[4]),
    .Q5(b_q5), .Q6(b_q6), .Q7(b_qn[5]), .Q8(b_qn[6]), .Q9(b_qn[7]),
    .EMPTY(b_e), .ALMOSTEMPTY(b_ae), .FULL(b_f), .ALMOSTFULL(b_af), .SCANOUT(b_so)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) d[i] = 8'h00;
    repeat (3) tick();
    chk("rst_a_empty", a_e, 1'b1);
    chk("rst_a_aempty", a_ae, 1'b1);
    chk("rst_a_full", a_f, 1'b0);
    chk("rst_a_afull", a_af, 1'b0);
    chk("rst_a_q0", a_qn[0], 4'h0);
    chk("scanout", a_so, 4'h0);
    #2 rst = 1'b0;

    // 8x4: one entry read as low then high nibble
    d[0] = 8'hA5; d[5] = 8'h3C; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    chk("w1_empty", a_e, 1'b0);
    chk("w1_aempty", a_ae, 1'b1);
    a_rd = 1'b1;
    tick();
    chk("x8_rd0_q0", a_qn[0], 4'h5);
    chk("x8_rd0_q5", a_q5, 8'h0C);
    chk("x8_rd0_empty", a_e, 1'b0);
    tick();
    a_rd = 1'b0;
    chk("x8_rd1_q0", a_qn[0], 4'hA);
    chk("x8_rd1_q5", a_q5, 8'h03);
    chk("x8_rd1_empty", a_e, 1'b1);

    // fill to full with WREN held
    a_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[0] = {4'(i), 4'(7 - i)};
      d[9] = {4'hC, 4'(i)};
      tick();
      chk($sformatf("fill%0d_afull", i), a_af, (i >= 6) ? 1'b1 : 1'b0);
      chk($sformatf("fill%0d_full", i), a_f, (i == 7) ? 1'b1 : 1'b0);
    end
    d[0] = 8'hFF; d[9] = 8'hFF;
    tick();
    a_wr = 1'b0;
    chk("ovf_full", a_f, 1'b1);

    // at full: low-nibble read, then read+write that pops and rejects the write
    a_rd = 1'b1;
    tick();
    chk("full_rd_q0", a_qn[0], 4'h7);
    chk("full_rd_q9", a_qn[7], 4'h0);
    chk("full_rd_full", a_f, 1'b1);
    a_wr = 1'b1; d[0] = 8'hEE; d[9] = 8'hEE;
    tick();
    a_wr = 1'b0;
    chk("full_rw_q0", a_qn[0], 4'h0);
    chk("full_rw_q9", a_qn[7], 4'hC);
    chk("full_rw_full", a_f, 1'b0);
    chk("full_rw_afull", a_af, 1'b1);

    // drain remaining entries 1..7 in order
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("rb%0d_lo_q0", i), a_qn[0], 4'(7 - i));
      chk($sformatf("rb%0d_lo_q9", i), a_qn[7], 4'(i));
      tick();
      chk($sformatf("rb%0d_hi_q0", i), a_qn[0], 4'(i));
      chk($sformatf("rb%0d_hi_q9", i), a_qn[7], 4'hC);
      chk($sformatf("rb%0d_empty", i), a_e, (i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("rb%0d_aempty", i), a_ae, (i >= 6) ? 1'b1 : 1'b0);
    end

    // at empty: read+write accepts the write, rejects the read
    a_wr = 1'b1; d[0] = 8'h5A; d[9] = 8'hC3;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("empty_rw_q0", a_qn[0], 4'h7);
    chk("empty_rw_empty", a_e, 1'b0);
    chk("empty_rw_aempty", a_ae, 1'b1);

    // asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_empty", a_e, 1'b1);
    chk("mid_rst_aempty", a_ae, 1'b1);
    chk("mid_rst_full", a_f, 1'b0);
    chk("mid_rst_afull", a_af, 1'b0);
    chk("mid_rst_q0", a_qn[0], 4'h0);
    #2 rst = 1'b0;
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("post_rst_rd_q0", a_qn[0], 4'h0);
    chk("post_rst_rd_empty", a_e, 1'b1);

    // 4x4 with output disable
    d[0] = 8'hA5; d[5] = 8'h3C; b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    chk("b_w_empty", b_e, 1'b0);
    b_rd = 1'b1;
    tick();
    chk("b_rd_q0", b_qn[0], 4'h5);
    chk("b_rd_q5", b_q5, 8'h3C);
    chk("b_rd_empty", b_e, 1'b1);
    b_rd = 1'b0;
    #1;
    chk("b_od_q0", b_qn[0], 4'h0);
    chk("b_od_q5", b_q5, 8'h00);

    // almost-empty margin of 2
    b_wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d[9] = 8'h90 + 8'(i);
      tick();
      chk($sformatf("b_ae_w%0d", i), b_ae, (i <= 2) ? 1'b1 : 1'b0);
    end
    b_wr = 1'b0; b_rd = 1'b1;
    tick();
    chk("b_ae_rd_q9", b_qn[7], 4'h1);
    chk("b_ae_rd_aempty", b_ae, 1'b1);
    b_rd = 1'b0;
    #1;
    chk("b_ae_od_q9", b_qn[7], 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sip_out_fifo_core.md
Name: sip_out_fifo_core

Overview:
Core storage and flag logic of the 7-series output FIFO, placed behind the OUT_FIFO simulation wrapper. It accepts ten 8-bit lanes (D0..D9) per write and returns 4-bit nibbles per read (Q5/Q6 8-bit). Depth is 8 write entries. It is a single-clock, synchronous FIFO that generates EMPTY, ALMOSTEMPTY, FULL and ALMOSTFULL flags.

Parameters:
ALMOST_EMPTY_VALUE, 8'h41, encoded threshold: 8'h41 means 1, 8'h63 means 2, any other value is treated as 1
ALMOST_FULL_VALUE, 8'h41, same encoding, gives the almost-full margin
ARRAY_MODE, 1'b1, 1 = 8x4 mode (two reads per entry), 0 = 4x4 mode (one read per entry)
OUTPUT_DISABLE, 1'b0, 1 = Q forced to 0 while RDEN is low

Ports:
CLK  in  1  single clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-high reset
GSR  in  1  global set/reset; asynchronous, active-high, ORed with RESET
D0..D9  in  8 each  write data lanes
WREN  in  1  write request
RDEN  in  1  read request
TESTWRITEDISB  in  1  active-low write disable (tie 1)
TESTREADDISB  in  1  active-low read disable (tie 1)
TESTMODEB, SCANENB  in  1  unused; tie 1
SCANIN  in  4  unused
Q0..Q4, Q7..Q9  out  4 each  read nibbles
Q5, Q6  out  8 each  read data for lanes 5 and 6
EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL  out  1 each  status flags
SCANOUT  out  4  constant 4'h0

Behaviour:
- Storage: 8 entries of 80 bits. State: 3-bit write pointer, 3-bit read pointer, 4-bit count (0..8), and a 1-bit nibble phase (8x4 mode only).
- Reset (RESET or GSR high, asynchronous):
  - pointers, count and phase cleared to 0
  - all Q registers cleared to 0
  - EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all data immediately.
- Write accept: WREN & !FULL & TESTWRITEDISB at the rising edge.
  - The entry at the write pointer stores {D9..D0}.
  - The write pointer wraps 7->0.
- A write while FULL is ignored. Contents and count are unchanged.
- Read accept: RDEN & !EMPTY & TESTREADDISB at the rising edge.
  - A read while EMPTY is ignored and Q holds its value.
- 4x4 mode, per accepted read:
  - Qn <= entry lane n [3:0] for n not in {5,6}
  - Q5, Q6 <= full 8-bit lanes
  - the entry is popped: read pointer +1, count -1
- 8x4 mode, per accepted read:
  - Phase 0: Qn <= lane[3:0]; Q5/Q6 <= {4'h0, lane[3:0]}; phase becomes 1; no pop.
  - Phase 1: Qn <= lane[7:4]; Q5/Q6 <= {4'h0, lane[7:4]}; phase becomes 0; the entry is popped.
- Read latency: Q updates at the same rising edge that accepts the read. Q holds between reads.
- Output disable: with OUTPUT_DISABLE=1, all Q outputs are combinationally 0 whenever RDEN=0. Otherwise they show the registered value.
- Simultaneous accepted read-pop and write leaves count unchanged; both pointers advance.
- Flag evaluation uses the flag values present at the edge:
  - at full, a read is accepted and the write is rejected
  - at empty, a write is accepted and the read is rejected
- Flags are registered and derived from the next count:
  - EMPTY: count==0
  - ALMOSTEMPTY: count <= AE (AE = 1 or 2), so it includes empty
  - FULL: count==8
  - ALMOSTFULL: count >= 8-AF (AF = 1 or 2), so it includes full
- In 8x4 mode an entry with only its low nibble read still counts as occupied.

Test Plan:
1. Assert RESET mid-stream -> immediately EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0, all Q=0. After release, a read is rejected.
2. 4x4 mode: write D0=8'hA5, D5=8'h3C, then read -> Q0=4'h5, Q5=8'h3C, EMPTY=1 after the read.
3. 8x4 mode: write D0=8'hA5, then two reads:
   - first read -> Q0=4'h5; EMPTY stays 0
   - second read -> Q0=4'hA; EMPTY=1
4. Write 8 entries with WREN held -> ALMOSTFULL=1 after 7 writes (AF=1), FULL=1 after 8. A 9th write is ignored, and reading back returns entries 0..7 in order.
5. At full, assert WREN and RDEN together -> one entry popped, write rejected, count=7. At empty, assert both -> write accepted, read rejected, count=1.
6. OUTPUT_DISABLE=1 -> Q=0 while RDEN=0; Q shows the read value while RDEN=1. With ALMOST_EMPTY_VALUE=8'h63, ALMOSTEMPTY=1 at count 2 and 0 at count 3.
